// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the shared 12-bit write port of the queue FIFO, with occupancy tracking.
// Optional FIFO_ARB_HOST_PRIO_EN: host wins every contested grant; rr is held at its reset value.
module fifo_write_arbiter #(
   parameter int DEPTH = 4096,
   parameter int LW    = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic [11:0]   cpu_data,
   output logic          cpu_ack,
   input  logic          host_req,
   input  logic [11:0]   host_data,
   output logic          host_ack,
   output logic          fifo_write,
   output logic [11:0]   fifo_data,
   input  logic          fifo_adv,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   typedef enum logic {
      RR_CPU  = 1'b0,
      RR_HOST = 1'b1
   } rr_t;

   localparam logic [LW:0]   CAP_EXT = (LW+1)'(DEPTH - 1);
   localparam logic [LW-1:0] CAP     = LW'(DEPTH - 1);

   rr_t         rr;
   rr_t         rr_next;
   logic        cpu_elig;
   logic        host_elig;
   logic        room;
   logic        grant_cpu;
   logic        grant_host;
   logic        dec;
   logic [LW:0] occupancy;

   // A requester whose ack is showing is dropping req this cycle and must not be granted again.
   assign cpu_elig  = cpu_req & ~cpu_ack;
   assign host_elig = host_req & ~host_ack;

   // The word already in flight to the FIFO has not reached level yet but occupies a slot.
   assign occupancy = {1'b0, level} + {{LW{1'b0}}, fifo_write};
   assign room      = occupancy < CAP_EXT;

   always_comb begin
      grant_cpu  = 1'b0;
      grant_host = 1'b0;
      rr_next    = rr;
      if (room) begin
`ifdef FIFO_ARB_HOST_PRIO_EN
         grant_host = host_elig;
         grant_cpu  = cpu_elig & ~host_elig;
         rr_next    = RR_CPU;
`else
         if (cpu_elig && host_elig) begin
            grant_cpu  = (rr == RR_CPU);
            grant_host = (rr == RR_HOST);
            rr_next    = (rr == RR_CPU) ? RR_HOST : RR_CPU;
         end else begin
            grant_cpu  = cpu_elig;
            grant_host = host_elig;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr         <= RR_CPU;
         cpu_ack    <= 1'b0;
         host_ack   <= 1'b0;
         fifo_write <= 1'b0;
         fifo_data  <= 12'h000;
      end else begin
         rr         <= rr_next;
         cpu_ack    <= grant_cpu;
         host_ack   <= grant_host;
         fifo_write <= grant_cpu | grant_host;
         if (grant_cpu) begin
            fifo_data <= cpu_data;
         end else if (grant_host) begin
            fifo_data <= host_data;
         end
      end
   end

   // An advance on an empty FIFO does not move its read pointer, so it must not move level either.
   assign dec = fifo_adv & (level != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         level <= '0;
      end else if (fifo_write && !dec) begin
         level <= level + 1'b1;
      end else if (!fifo_write && dec) begin
         level <= level - 1'b1;
      end
   end

   assign full  = (level == CAP);
   assign empty = (level == '0);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed tables and sequences plus randomized traffic against a cycle model.
module tb_fifo_write_arbiter;

   localparam int DEPTH = 4096;
   localparam int LW    = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req;
   logic [11:0]   cpu_data;
   logic          cpu_ack;
   logic          host_req;
   logic [11:0]   host_data;
   logic          host_ack;
   logic          fifo_write;
   logic [11:0]   fifo_data;
   logic          fifo_adv;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;

   int checks = 0;
   int errors = 0;

   fifo_write_arbiter #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
      .host_req(host_req), .host_data(host_data), .host_ack(host_ack),
      .fifo_write(fifo_write), .fifo_data(fifo_data), .fifo_adv(fifo_adv),
      .level(level), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Reference state: what the outputs should be after the most recent edge.
   bit          m_cack, m_hack, m_fw, m_rr_host;
   logic [11:0] m_fd;
   int          m_level;
   bit          n_cack, n_hack, n_fw, n_rr_host;
   logic [11:0] n_fd;
   int          n_level;

   int writes_seen, cack_seen, hack_seen;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_eval();
      bit ce, he, gc, gh;
      if (rst) begin
         n_cack = 0; n_hack = 0; n_fw = 0; n_fd = 12'h000; n_level = 0; n_rr_host = 0;
         return;
      end
      ce = cpu_req && !m_cack;
      he = host_req && !m_hack;
      gc = 0; gh = 0;
      n_rr_host = m_rr_host;
      if (m_level + int'(m_fw) < DEPTH - 1) begin
         if (ce && he) begin
`ifdef FIFO_ARB_HOST_PRIO_EN
            gh = 1;
`else
            if (m_rr_host) gh = 1; else gc = 1;
            n_rr_host = !m_rr_host;
`endif
         end else begin
            gc = ce;
            gh = he;
         end
      end
      n_cack  = gc;
      n_hack  = gh;
      n_fw    = gc || gh;
      n_fd    = gc ? cpu_data : (gh ? host_data : m_fd);
      n_level = m_level + int'(m_fw) - ((fifo_adv && m_level > 0) ? 1 : 0);
   endtask

   function automatic logic [31:0] dut_vec();
      return {3'b0, cpu_ack, host_ack, fifo_write, (m_fw ? fifo_data : 12'h000), level, full, empty};
   endfunction

   function automatic logic [31:0] model_vec();
      logic [11:0] lv;
      lv = 12'(m_level);
      return {3'b0, m_cack, m_hack, m_fw, (m_fw ? m_fd : 12'h000), lv,
              (m_level == DEPTH - 1), (m_level == 0)};
   endfunction

   // One clock: predict, advance, sample 1 ns after the edge, compare.
   task automatic tick(input string name);
      model_eval();
      @(posedge clk);
      #1;
      m_cack = n_cack; m_hack = n_hack; m_fw = n_fw; m_fd = n_fd;
      m_level = n_level; m_rr_host = n_rr_host;
      if (fifo_write) writes_seen++;
      if (cpu_ack) cack_seen++;
      if (host_ack) hack_seen++;
      check(name, dut_vec(), model_vec());
   endtask

   task automatic do_reset();
      rst = 1; cpu_req = 0; host_req = 0; fifo_adv = 0; cpu_data = 0; host_data = 0;
      tick("reset");
      tick("reset");
      rst = 0;
   endtask

   typedef struct {
      logic        creq;
      logic [11:0] cdata;
      logic        hreq;
      logic [11:0] hdata;
      logic        adv;
      logic        e_cack;
      logic        e_hack;
      logic        e_fw;
      logic [11:0] e_fd;
      int          e_level;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef FIFO_ARB_HOST_PRIO_EN
      tbl[0] = '{1, 12'hAAA, 1, 12'h555, 0, 0, 1, 1, 12'h555, 0};
      tbl[1] = '{1, 12'hAAA, 1, 12'h555, 0, 1, 0, 1, 12'hAAA, 1};
      tbl[2] = '{1, 12'hAAA, 1, 12'h555, 0, 0, 1, 1, 12'h555, 2};
      tbl[3] = '{1, 12'hAAA, 1, 12'h555, 0, 1, 0, 1, 12'hAAA, 3};
`else
      tbl[0] = '{1, 12'hAAA, 1, 12'h555, 0, 1, 0, 1, 12'hAAA, 0};
      tbl[1] = '{1, 12'hAAA, 1, 12'h555, 0, 0, 1, 1, 12'h555, 1};
      tbl[2] = '{1, 12'hAAA, 1, 12'h555, 0, 1, 0, 1, 12'hAAA, 2};
      tbl[3] = '{1, 12'hAAA, 1, 12'h555, 0, 0, 1, 1, 12'h555, 3};
`endif
      tbl[4] = '{0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 12'h000, 4};

      // Reset values
      do_reset();
      check("reset_outputs", {cpu_ack, host_ack, fifo_write, fifo_data, level, full, empty},
            {3'b000, 12'h000, 12'h000, 1'b0, 1'b1});

      // Single CPU write
      cack_seen = 0;
      cpu_req = 1; cpu_data = 12'h123;
      tick("t1_grant");
      check("t1_fw", {31'b0, fifo_write}, 32'd1);
      check("t1_fd", {20'b0, fifo_data}, 32'h123);
      cpu_req = 0;
      tick("t1_after");
      tick("t1_idle");
      check("t1_level", {20'b0, level}, 32'd1);
      check("t1_empty", {31'b0, empty}, 32'd0);
      check("t1_ack_pulses", cack_seen, 32'd1);

      // Contested writes alternate
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cpu_req = tbl[i].creq; cpu_data = tbl[i].cdata;
         host_req = tbl[i].hreq; host_data = tbl[i].hdata; fifo_adv = tbl[i].adv;
         tick("t2_model");
         check($sformatf("t2_v%0d_acks", i), {30'b0, cpu_ack, host_ack}, {30'b0, tbl[i].e_cack, tbl[i].e_hack});
         check($sformatf("t2_v%0d_fw", i), {31'b0, fifo_write}, {31'b0, tbl[i].e_fw});
         if (tbl[i].e_fw)
            check($sformatf("t2_v%0d_fd", i), {20'b0, fifo_data}, {20'b0, tbl[i].e_fd});
         check($sformatf("t2_v%0d_level", i), {20'b0, level}, tbl[i].e_level);
      end

      // Held request never writes back-to-back
      do_reset();
      cpu_req = 1; cpu_data = 12'h0F0;
      tick("t6_a");
      check("t6_first", {31'b0, fifo_write}, 32'd1);
      tick("t6_b");
      check("t6_gap", {31'b0, fifo_write}, 32'd0);
      tick("t6_c");
      check("t6_second", {31'b0, fifo_write}, 32'd1);
      cpu_req = 0;
      tick("t6_d");

      // Coincident write and advance at level 5, then drain past empty
      do_reset();
      cpu_req = 1; host_req = 1; cpu_data = 12'h111; host_data = 12'h222;
      for (int i = 0; i < 6; i++) tick("t4_fill");
      check("t4_pre_level", {20'b0, level}, 32'd5);
      check("t4_pre_fw", {31'b0, fifo_write}, 32'd1);
      cpu_req = 0; host_req = 0; fifo_adv = 1;
      tick("t4_coincide");
      check("t4_level_held", {20'b0, level}, 32'd5);
      for (int i = 0; i < 10; i++) tick("t4_drain");
      fifo_adv = 0;
      check("t4_level_zero", {20'b0, level}, 32'd0);
      check("t4_empty", {31'b0, empty}, 32'd1);

      // Reset discards a pending grant
      do_reset();
      cpu_req = 1; cpu_data = 12'h777; rst = 1;
      tick("t5_rst_same");
      check("t5_no_ack", {30'b0, cpu_ack, fifo_write}, 32'd0);
      rst = 0;
      tick("t5_grant");
      rst = 1;
      tick("t5_rst_after");
      check("t5_cleared", {30'b0, cpu_ack, fifo_write}, 32'd0);
      check("t5_level", {20'b0, level}, 32'd0);
      check("t5_empty", {31'b0, empty}, 32'd1);
      rst = 0; cpu_req = 0;
      tick("t5_idle");
      check("t5_level_stays", {20'b0, level}, 32'd0);

      // Fill to capacity with both requesters active
      do_reset();
      cpu_req = 1; host_req = 1; cpu_data = 12'hC0C; host_data = 12'h0C0;
      writes_seen = 0;
      for (int i = 0; i < 4150; i++) tick("t3_fill");
      check("t3_writes", writes_seen, 32'd4095);
      check("t3_level", {20'b0, level}, 32'd4095);
      check("t3_full", {31'b0, full}, 32'd1);
      cack_seen = 0; hack_seen = 0; writes_seen = 0;
      for (int i = 0; i < 10; i++) tick("t3_hold");
      check("t3_no_acks", cack_seen + hack_seen + writes_seen, 32'd0);
      fifo_adv = 1;
      tick("t3_adv");
      fifo_adv = 0;
      for (int i = 0; i < 10; i++) tick("t3_refill");
      check("t3_one_more", writes_seen, 32'd1);
      check("t3_full_again", {31'b0, full}, 32'd1);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (cpu_req) begin
            if (cpu_ack) begin
               if ($urandom_range(1, 0) == 0) cpu_req = 0;
               else cpu_data = 12'($urandom);
            end
         end else if ($urandom_range(2, 0) != 0) begin
            cpu_req = 1; cpu_data = 12'($urandom);
         end
         if (host_req) begin
            if (host_ack) begin
               if ($urandom_range(1, 0) == 0) host_req = 0;
               else host_data = 12'($urandom);
            end
         end else if ($urandom_range(2, 0) != 0) begin
            host_req = 1; host_data = 12'($urandom);
         end
         fifo_adv = ($urandom_range(2, 0) == 0);
         rst = ($urandom_range(199, 0) == 0);
         tick("rand");
      end
      rst = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares the single 12-bit write port of the design's queue FIFO between two producers: the CPU output path (cpu) and the host/test loader (host). It arbitrates requests round-robin, tracks queue occupancy, and produces full/empty status. The FIFO's write port has no full flag of its own, so this block is the only thing that stops an overflow. The block sits directly in front of the FIFO. Its fifo_write/fifo_data outputs drive the FIFO's write strobe and data input. It snoops the consumer's advance strobe.

Parameters:
DEPTH, 4096, number of FIFO address slots; usable capacity is DEPTH-1 because equal pointers mean empty.
LW, 12, width of the level counter; must satisfy 2^LW >= DEPTH.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; also resets the FIFO in the same cycle
cpu_req  in  1  CPU write request; held until cpu_ack
cpu_data  in  12  CPU write data; stable while cpu_req is high
cpu_ack  out  1  one-cycle pulse: the CPU word has been written
host_req  in  1  host write request; held until host_ack
host_data  in  12  host write data
host_ack  out  1  one-cycle pulse: the host word has been written
fifo_write  out  1  registered write strobe to the FIFO
fifo_data  out  12  registered write data to the FIFO
fifo_adv  in  1  consumer advance strobe, the same signal that drives the FIFO
level  out  LW  number of words currently queued
full  out  1  level == DEPTH-1
empty  out  1  level == 0

Behaviour:
- Reset values:
  - cpu_ack, host_ack and fifo_write = 0.
  - fifo_data = 0 and level = 0.
  - full = 0 and empty = 1.
  - Round-robin pointer rr = cpu, so the CPU has priority first.
- Eligibility: a requester is eligible in cycle N if its req = 1 and its ack = 0 in cycle N. A requester whose ack is high is ignored that cycle, which prevents a double write while the requester drops req.
- Space check: room = (level + fifo_write) < DEPTH-1. The in-flight write counts against capacity.
- Grant, evaluated in cycle N:
  - If room = 1 and only one requester is eligible, grant it.
  - If room = 1 and both are eligible, grant the one rr points to, then flip rr to the other.
  - If room = 0, grant nothing and leave rr unchanged.
- Latency: a grant in cycle N produces the following in cycle N+1, all for one cycle:
  - fifo_write = 1;
  - fifo_data = the granted requester's data, sampled at the N edge;
  - the granted requester's ack = 1.
- Throughput:
  - One write per cycle when both requesters are active (they alternate).
  - One write per two cycles for a single requester.
- Level update each cycle:
  - inc = fifo_write;
  - dec = fifo_adv & (level != 0);
  - level += inc - dec.
  - Simultaneous write and advance leaves level unchanged.
  - An advance while empty is ignored, matching the FIFO's behaviour of not moving its read pointer when empty.
- full and empty are combinational decodes of the level register.
- Level wrap: level never exceeds DEPTH-1 and never goes below 0; no modular wrap is permitted.
- Reset mid-operation:
  - Pending grants are discarded.
  - No ack is issued for a request that was sampled but not yet written.
  - Requesters re-present after reset.
- No state machine beyond rr and the pipeline register. Each requester's handshake is Idle -> Req -> Ack -> Idle.

Optional Feature:
FIFO_ARB_HOST_PRIO_EN
- Defined: fixed priority. The host always wins when both requesters are eligible, and rr is unused and held at its reset value. This is used when test vectors must be loaded ahead of CPU output.
- Undefined: round-robin as described above.

Test Plan:
1. After reset, only cpu_req = 1 with cpu_data = 0x123 -> fifo_write = 1 and fifo_data = 0x123 one cycle later, cpu_ack pulses once, level = 1, empty = 0.
2. Both requesters held high with cpu_data = 0xAAA and host_data = 0x555 for 4 cycles -> writes alternate 0xAAA, 0x555, 0xAAA, 0x555 on consecutive cycles; level = 4. With FIFO_ARB_HOST_PRIO_EN defined, the host word is written first.
3. Fill to level = 4094 with cpu_req and host_req both high -> exactly one more write; full = 1 at level = 4095; no further acks until fifo_adv pulses, after which exactly one write is accepted.
4. At level = 5, fifo_write and fifo_adv coincide -> level stays 5. Then fifo_adv held high for 10 cycles with no writes -> level falls to 0 and stays 0; empty = 1.
5. Assert rst in the cycle after a grant -> no ack and no fifo_write in the following cycle; level = 0 and empty = 1.
6. cpu_req held high across its ack cycle -> the second write occurs two cycles after the first, never back-to-back.
